// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO between ID and the reservation stations, snooping the CDB while entries wait.
// Optional DISPATCH_BYPASS_EN: an instruction arriving at an empty queue issues straight to its RS.
`timescale 1ns/1ps
module dispatch_queue #(
    parameter int DEPTH     = 4,
    parameter int NUM_UNITS = 3,
    parameter int UNIT_W    = 2,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 4,
    parameter int OP_W      = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [UNIT_W-1:0]    id_unit,
    input  logic [OP_W-1:0]      id_op,
    input  logic [DATA_W-1:0]    id_imm,
    input  logic [DATA_W-1:0]    id_pc,
    input  logic [TAG_W-1:0]     id_dest_tag,
    input  logic                 id_rs1_valid,
    input  logic [DATA_W-1:0]    id_rs1_data,
    input  logic [TAG_W-1:0]     id_rs1_tag,
    input  logic                 id_rs2_valid,
    input  logic [DATA_W-1:0]    id_rs2_data,
    input  logic [TAG_W-1:0]     id_rs2_tag,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [DATA_W-1:0]    cdb_data,
    input  logic [NUM_UNITS-1:0] rs_full,
    output logic [NUM_UNITS-1:0] out_enable,
    output logic [OP_W-1:0]      out_op,
    output logic [DATA_W-1:0]    out_imm,
    output logic [DATA_W-1:0]    out_pc,
    output logic [TAG_W-1:0]     out_dest_tag,
    output logic                 out_reg1_valid,
    output logic [DATA_W-1:0]    out_reg1_data,
    output logic [TAG_W-1:0]     out_reg1_tag,
    output logic                 out_reg2_valid,
    output logic [DATA_W-1:0]    out_reg2_data,
    output logic [TAG_W-1:0]     out_reg2_tag
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } opnd_t;

    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;

    logic [UNIT_W-1:0] q_unit [DEPTH];
    logic [OP_W-1:0]   q_op   [DEPTH];
    logic [DATA_W-1:0] q_imm  [DEPTH];
    logic [DATA_W-1:0] q_pc   [DEPTH];
    logic [TAG_W-1:0]  q_dest [DEPTH];
    opnd_t             q_rs1  [DEPTH];
    opnd_t             q_rs2  [DEPTH];

    logic  cdb_live;
    opnd_t id_rs1_raw, id_rs2_raw, in_rs1, in_rs2, hd_rs1, hd_rs2;
    logic  head_in_range, head_blocked;
    logic  do_enq, head_go, do_pop, do_issue, do_bypass, do_write;

    logic [UNIT_W-1:0] sel_unit;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_imm, sel_pc;
    logic [TAG_W-1:0]  sel_dest;
    opnd_t             sel_rs1, sel_rs2;

    // A Null tag (0) never resolves, so a zero broadcast is ignored entirely.
    function automatic opnd_t snoop(input opnd_t o, input logic live,
                                    input logic [TAG_W-1:0] ctag, input logic [DATA_W-1:0] cdata);
        opnd_t r;
        r = o;
        if (live && !o.valid && (o.tag == ctag)) begin
            r.valid = 1'b1;
            r.data  = cdata;
            r.tag   = '0;
        end
        return r;
    endfunction

    assign cdb_live   = cdb_valid & rdy_in & (cdb_tag != '0);
    assign id_rs1_raw = {id_rs1_valid, id_rs1_data, id_rs1_tag};
    assign id_rs2_raw = {id_rs2_valid, id_rs2_data, id_rs2_tag};
    assign in_rs1     = snoop(id_rs1_raw, cdb_live, cdb_tag, cdb_data);
    assign in_rs2     = snoop(id_rs2_raw, cdb_live, cdb_tag, cdb_data);
    assign hd_rs1     = snoop(q_rs1[head], cdb_live, cdb_tag, cdb_data);
    assign hd_rs2     = snoop(q_rs2[head], cdb_live, cdb_tag, cdb_data);

    always_comb begin
        head_in_range = 1'b0;
        head_blocked  = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (q_unit[head] == u[UNIT_W-1:0]) begin
                head_in_range = 1'b1;
                head_blocked  = rs_full[u];
            end
        end
    end

    assign id_ready = (count < DEPTH_C);
    assign do_enq   = id_valid & id_ready & rdy_in & ~flush_in;
    assign head_go  = (count != '0) & rdy_in & ~flush_in;
    // An out-of-range head is dropped rather than stalling the queue forever.
    assign do_pop   = head_go & ~head_blocked;
    assign do_issue = do_pop & head_in_range;

`ifdef DISPATCH_BYPASS_EN
    logic id_in_range, id_blocked;
    always_comb begin
        id_in_range = 1'b0;
        id_blocked  = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (id_unit == u[UNIT_W-1:0]) begin
                id_in_range = 1'b1;
                id_blocked  = rs_full[u];
            end
        end
    end
    assign do_bypass = do_enq & (count == '0) & id_in_range & ~id_blocked;
`else
    assign do_bypass = 1'b0;
`endif

    assign do_write = do_enq & ~do_bypass;

    assign sel_unit = do_bypass ? id_unit     : q_unit[head];
    assign sel_op   = do_bypass ? id_op       : q_op[head];
    assign sel_imm  = do_bypass ? id_imm      : q_imm[head];
    assign sel_pc   = do_bypass ? id_pc       : q_pc[head];
    assign sel_dest = do_bypass ? id_dest_tag : q_dest[head];
    assign sel_rs1  = do_bypass ? in_rs1      : hd_rs1;
    assign sel_rs2  = do_bypass ? in_rs2      : hd_rs2;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            out_enable     <= '0;
            out_op         <= '0;
            out_imm        <= '0;
            out_pc         <= '0;
            out_dest_tag   <= '0;
            out_reg1_valid <= 1'b0;
            out_reg1_data  <= '0;
            out_reg1_tag   <= '0;
            out_reg2_valid <= 1'b0;
            out_reg2_data  <= '0;
            out_reg2_tag   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_unit[i] <= '0;
                q_op[i]   <= '0;
                q_imm[i]  <= '0;
                q_pc[i]   <= '0;
                q_dest[i] <= '0;
                q_rs1[i]  <= '0;
                q_rs2[i]  <= '0;
            end
        end else if (rdy_in) begin
            out_enable <= '0;
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    q_rs1[i] <= snoop(q_rs1[i], cdb_live, cdb_tag, cdb_data);
                    q_rs2[i] <= snoop(q_rs2[i], cdb_live, cdb_tag, cdb_data);
                end
                if (do_write) begin
                    q_unit[tail] <= id_unit;
                    q_op[tail]   <= id_op;
                    q_imm[tail]  <= id_imm;
                    q_pc[tail]   <= id_pc;
                    q_dest[tail] <= id_dest_tag;
                    q_rs1[tail]  <= in_rs1;
                    q_rs2[tail]  <= in_rs2;
                    tail         <= tail + PTR_W'(1);
                end
                if (do_pop)
                    head <= head + PTR_W'(1);
                case ({do_write, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
                if (do_issue || do_bypass) begin
                    out_op         <= sel_op;
                    out_imm        <= sel_imm;
                    out_pc         <= sel_pc;
                    out_dest_tag   <= sel_dest;
                    out_reg1_valid <= sel_rs1.valid;
                    out_reg1_data  <= sel_rs1.data;
                    out_reg1_tag   <= sel_rs1.tag;
                    out_reg2_valid <= sel_rs2.valid;
                    out_reg2_data  <= sel_rs2.data;
                    out_reg2_tag   <= sel_rs2.tag;
                    for (int u = 0; u < NUM_UNITS; u++) begin
                        if (sel_unit == u[UNIT_W-1:0])
                            out_enable[u] <= 1'b1;
                    end
                end
            end
        end else begin
            out_enable <= '0;
        end
    end

endmodule
